// File: rtl/rot_pipe_ctrl.sv
// Issue/collect controller around the 5-stage pipelined right rotator.
// Credit-based admission sizes requests so the result FIFO can never overflow.
module rot_pipe_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [TAGW-1:0]  in_tag,
  output logic [WIDTH-1:0] rot_a,
  output logic [SHW-1:0]   rot_s,
  input  logic [WIDTH-1:0] rot_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [TAGW-1:0]  out_tag,
  output logic [2:0]       inflight,
  output logic [3:0]       count,
  output logic             busy
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SBW = SHW + TAGW;

  logic             fire_s;
  logic             wr_s;
  logic             pop_s;
  logic             in_ready_s;
  logic [LAT-1:0]   v_r;
  logic [SBW-1:0]   sb_r [LAT];
  logic [2:0]       inflight_r;
  logic [2:0]       inflight_nxt_s;
  logic [3:0]       count_r;
  logic [3:0]       count_nxt_s;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic [SBW-1:0]   sb_mem_r [DEPTH];
  logic [WIDTH-1:0] head_data_s;
  logic [SBW-1:0]   head_sb_s;

  // Credits counted from registers only, so out_ready never reaches in_ready.
  assign in_ready_s = (5'(inflight_r) + 5'(count_r)) < 5'(DEPTH);
  assign fire_s     = in_valid & in_ready_s;
  assign wr_s       = v_r[LAT-1];
  assign pop_s      = (count_r != 4'd0) & out_ready;

  assign in_ready  = in_ready_s;
  assign rot_a     = in_data;
  assign rot_s     = in_amt;
  assign out_valid = (count_r != 4'd0);
  assign out_data  = head_data_s;
  assign out_amt   = head_sb_s[SBW-1:TAGW];
  assign out_tag   = head_sb_s[TAGW-1:0];
  assign inflight  = inflight_r;
  assign count     = count_r;
  assign busy      = (inflight_r != 3'd0) | (count_r != 4'd0);

  // Next in-flight and FIFO occupancy counts
  always_comb begin
    inflight_nxt_s = inflight_r;
    count_nxt_s    = count_r;
    case ({fire_s, wr_s})
      2'b10:   inflight_nxt_s = inflight_r + 3'd1;
      2'b01:   inflight_nxt_s = inflight_r - 3'd1;
      default: inflight_nxt_s = inflight_r;
    endcase
    case ({wr_s, pop_s})
      2'b10:   count_nxt_s = count_r + 4'd1;
      2'b01:   count_nxt_s = count_r - 4'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Valid/sideband tracking pipes, counters and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r        <= '0;
      for (int k = 0; k < LAT; k++) sb_r[k] <= '0;
      inflight_r <= 3'd0;
      count_r    <= 4'd0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
    end else begin
      v_r     <= {v_r[LAT-2:0], fire_s};
      sb_r[0] <= {in_amt, in_tag};
      for (int k = 1; k < LAT; k++) sb_r[k] <= sb_r[k-1];
      inflight_r <= inflight_nxt_s;
      count_r    <= count_nxt_s;
      if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (wr_s) begin
      data_mem_r[wr_ptr_r] <= rot_y;
      sb_mem_r[wr_ptr_r]   <= sb_r[LAT-1];
    end
  end

  // FIFO head, forced to zero while empty so stale entries never leak out
  always_comb begin
    if (count_r != 4'd0) begin
      head_data_s = data_mem_r[rd_ptr_r];
      head_sb_s   = sb_mem_r[rd_ptr_r];
    end else begin
      head_data_s = '0;
      head_sb_s   = '0;
    end
  end

  rot_pipe_ctrl_chk #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr_s),
    .pop      (pop_s),
    .count    (count_r),
    .inflight (inflight_r)
  );
endmodule

// Invariant checker: the FIFO never overflows and the in-flight count stays within the rotator latency.
module rot_pipe_ctrl_chk #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  input logic       wr,
  input logic       pop,
  input logic [3:0] count,
  input logic [2:0] inflight
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr && !pop && (count == 4'(DEPTH))));
  a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
    (inflight <= 3'(LAT)));
endmodule

// File: tb/tb_rot_pipe_ctrl.sv
// Directed bench for rot_pipe_ctrl with a behavioural 5-stage rotator model
// and an in-order scoreboard checked on every output handshake.
module tb_rot_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_amt = 5'd0;
  logic [3:0]  in_tag = 4'd0;
  logic [31:0] rot_a;
  logic [4:0]  rot_s;
  logic [31:0] rot_y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_amt;
  logic [3:0]  out_tag;
  logic [2:0]  inflight;
  logic [3:0]  count;
  logic        busy;

  always #5 clk = ~clk;

  rot_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .rot_a(rot_a), .rot_s(rot_s), .rot_y(rot_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_amt(out_amt), .out_tag(out_tag),
    .inflight(inflight), .count(count), .busy(busy)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // Rotator model: no reset, result appears 5 edges after sampling a/s
  logic [31:0] rp [5];
  always_ff @(posedge clk) begin
    rp[0] <= ror(rot_a, rot_s);
    for (int k = 1; k < 5; k++) rp[k] <= rp[k-1];
  end
  assign rot_y = rp[4];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [3:0]  t;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [3:0]  t;
    logic [31:0] e;
  } vec_t;

  exp_t sb_q[$];
  int pass_n = 0, total_n = 0;
  int pops_n = 0, acc_n = 0, cyc_n = 0;
  int first_pop = -1, last_pop = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // One clock cycle: drive inputs, score the handshakes that the next edge will perform
  task automatic cyc(input logic iv, input logic [31:0] d, input logic [4:0] a,
                     input logic [3:0] t, input logic [31:0] e, input logic ordy);
    exp_t x;
    in_valid = iv; in_data = d; in_amt = a; in_tag = t; out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) chk("pop_unexpected", 32'(sb_q.size()), 32'd1);
      else begin
        x = sb_q.pop_front();
        chk("pop_data", out_data, x.d);
        chk("pop_amt", 32'(out_amt), 32'(x.a));
        chk("pop_tag", 32'(out_tag), 32'(x.t));
      end
      pops_n++;
      if (first_pop < 0) first_pop = cyc_n;
      last_pop = cyc_n;
    end
    if (iv && in_ready) begin
      x.d = e; x.a = a; x.t = t;
      sb_q.push_back(x);
      acc_n++;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_count"}, 32'(count), 32'd0);
    chk({name, "_inflight"}, 32'(inflight), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_out_data"}, out_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n, p0, a0, drops;
    vecs[0] = '{32'h1234_5678, 5'd4,  4'd3, 32'h8123_4567};
    vecs[1] = '{32'hDEAD_BEEF, 5'd0,  4'd5, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0001, 5'd1,  4'd6, 32'h8000_0000};
    vecs[3] = '{32'h8000_0000, 5'd31, 4'd7, 32'h0000_0001};
    vecs[4] = '{32'hF000_0000, 5'd4,  4'd8, 32'h0F00_0000};
    vecs[5] = '{32'h0000_FFFF, 5'd16, 4'd9, 32'hFFFF_0000};
    vecs[6] = '{32'h0000_0003, 5'd1,  4'd10, 32'h8000_0001};

    @(posedge clk); #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requests: latency, result and sideband
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, vecs[i].d, vecs[i].a, vecs[i].t, vecs[i].e, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
        cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b0);
        n++;
      end
      chk("vec_latency", 32'(n), 32'd5);
      chk("vec_data", out_data, vecs[i].e);
      chk("vec_amt", 32'(out_amt), 32'(vecs[i].a));
      chk("vec_tag", 32'(out_tag), 32'(vecs[i].t));
      chk("vec_count", 32'(count), 32'd1);
      chk("vec_inflight", 32'(inflight), 32'd0);
      cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
      chk("vec_count_after", 32'(count), 32'd0);
      chk("vec_busy_after", 32'(busy), 32'd0);
    end

    // Back-to-back 32 requests with out_ready high
    p0 = pops_n; first_pop = -1; last_pop = -1; drops = 0;
    for (int i = 0; i < 32; i++) begin
      if (!in_ready) drops++;
      if (i == 20) begin
        chk("b2b_inflight", 32'(inflight), 32'd5);
        chk("b2b_count", 32'(count), 32'd1);
      end
      cyc(1'b1, 32'(i), 5'(i), 4'(i), ror(32'(i), 5'(i)), 1'b1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
      n++;
    end
    chk("b2b_in_ready_drops", 32'(drops), 32'd0);
    chk("b2b_pops", 32'(pops_n - p0), 32'd32);
    chk("b2b_span", 32'(last_pop - first_pop), 32'd31);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // Backpressure: only DEPTH requests admitted
    a0 = acc_n;
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 32'hA000_0000 | 32'(k), 5'(k), 4'(k), ror(32'hA000_0000 | 32'(k), 5'(k)), 1'b0);
    chk("bp_accepted", 32'(acc_n - a0), 32'd8);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd8);
    chk("bp_inflight", 32'(inflight), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_tag", 32'(out_tag), 32'd0);

    // Pop at full while offering a request, then pop and accept together
    a0 = acc_n;
    cyc(1'b1, 32'h5555_0001, 5'd7, 4'hE, ror(32'h5555_0001, 5'd7), 1'b1);
    chk("full_no_accept", 32'(acc_n - a0), 32'd0);
    chk("full_count_after_pop", 32'(count), 32'd7);
    chk("full_in_ready_back", 32'(in_ready), 32'd1);
    cyc(1'b1, 32'h5555_0001, 5'd7, 4'hE, ror(32'h5555_0001, 5'd7), 1'b1);
    chk("full_accept", 32'(acc_n - a0), 32'd1);
    chk("full_count_both", 32'(count), 32'd6);
    chk("full_inflight_both", 32'(inflight), 32'd1);
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
      n++;
    end
    chk("bp_drained", 32'(sb_q.size()), 32'd0);
    chk_idle("bp_end");

    // Write and pop on the same edge at count 1
    cyc(1'b1, 32'h0000_00F0, 5'd4, 4'h1, 32'h0000_000F, 1'b0);
    cyc(1'b1, 32'h0000_0F00, 5'd8, 4'h2, 32'h0000_000F, 1'b0);
    n = 0;
    while (count != 4'd1 && n < 20) begin
      cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b0);
      n++;
    end
    chk("wp_pre_count", 32'(count), 32'd1);
    chk("wp_pre_inflight", 32'(inflight), 32'd1);
    cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
    chk("wp_count", 32'(count), 32'd1);
    chk("wp_inflight", 32'(inflight), 32'd0);
    chk("wp_head_tag", 32'(out_tag), 32'd2);
    cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
    chk("wp_final_count", 32'(count), 32'd0);

    // Reset in the middle of a 3-request burst
    cyc(1'b1, 32'h1111_1111, 5'd1, 4'h4, 32'd0, 1'b0);
    cyc(1'b1, 32'h2222_2222, 5'd2, 4'h5, 32'd0, 1'b0);
    cyc(1'b1, 32'h3333_3333, 5'd3, 4'h6, 32'd0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    p0 = pops_n;
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'd0, 5'd0, 4'd0, 32'd0, 1'b1);
    chk("midrst_no_stale", 32'(pops_n - p0), 32'd0);
    chk_idle("midrst_end");

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/rot_pipe_ctrl.md
# rot_pipe_ctrl

Issue/collect controller that wraps the 5-stage pipelined 32-bit right rotator (`rotator`). Accepts rotate requests on a valid/ready port and drives the rotator's `a`/`s` inputs. Tracks each request through the rotator's fixed latency with a valid/sideband shift pipe, then captures results into a result FIFO presented on a valid/ready output port. Credit-based admission guarantees the FIFO can never overflow, so the rotator itself needs no stall.

## Interface
- `WIDTH`, 32, data width; must match the rotator.
- `SHW`, 5, shift-amount width (log2 WIDTH).
- `LAT`, 5, rotator latency in clk edges from sampling `a`/`s` to a valid `y`.
- `DEPTH`, 8, result FIFO entries; power of two, ≥ LAT+1.
- `TAGW`, 4, request tag width.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge; shared with the rotator.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: controller can accept.
- `in_data` in WIDTH: operand to rotate.
- `in_amt` in SHW: right-rotate amount.
- `in_tag` in TAGW: opaque tag, returned with the result.
- `rot_a` out WIDTH: to rotator `a`.
- `rot_s` out SHW: to rotator `s`.
- `rot_y` in WIDTH: from rotator `y`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_data` out WIDTH: rotated result.
- `out_amt` out SHW: amount used.
- `out_tag` out TAGW: tag of the request.
- `inflight` out 3: requests inside the rotator (0..LAT).
- `count` out 4: FIFO occupancy (0..DEPTH).
- `busy` out 1: `inflight` ≠ 0 or `count` ≠ 0.

## Operation
- Reset: all outputs 0 (`in_ready` reads 1 after reset because the credit check passes). Valid pipe, sideband pipe, counters and FIFO pointers are cleared.
- Admission: `in_ready` = (`inflight` + `count`) < DEPTH. This is computed from registers only, with no combinational path from `out_ready`. `fire` = `in_valid` & `in_ready`.
- Drive: `rot_a` = `in_data` and `rot_s` = `in_amt`, combinational pass-through. The rotator samples them on the edge where `fire` is high. Values while `fire`=0 are don't-care.
- Tracking:
  - Valid pipe `v[0..LAT-1]`: `v[0]` <= `fire`, `v[k]` <= `v[k-1]`.
  - Sideband pipe carries `{in_amt, in_tag}` alongside it.
  - `inflight` +1 on `fire`, −1 when `v[LAT-1]`=1. Both in one cycle means no change.
- Capture: while `v[LAT-1]`=1, `rot_y` holds that request's result. On that edge it is written into the FIFO with its sideband.
- Output: `out_valid` = `count` ≠ 0. `out_*` show the FIFO head. Pop on `out_valid` & `out_ready`.
- Simultaneous FIFO write and pop is legal at any occupancy, including full and empty.
- Pointers wrap modulo DEPTH.
- Overflow is impossible by construction: a write at `count`=DEPTH is an assertion failure.
- Popping while empty is ignored.
- Results return in request order.
- Reset mid-operation discards all in-flight and buffered results. The rotator has no reset, so stale `rot_y` values are ignored because `v` is cleared.

## Timing
- Accept edge E0. `v[LAT-1]` is high in the cycle after E(LAT-1). FIFO write at E(LAT).
- `out_valid` rises after E(LAT): accept-to-output latency is LAT+1 = 6 cycles when the FIFO was empty.
- Throughput is 1 request/cycle sustained with `out_ready` held high. Steady state is `inflight`=5, `count`≤1, sum < 8.
- With `out_ready`=0, at most DEPTH requests are accepted in total. `in_ready` falls in the cycle after the DEPTH-th accept and never drops a result.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset: assert `rst_n`=0 mid-burst of 3 requests → all outputs 0, `in_ready`=1 after release. No stale result appears within 20 cycles.
- Single request: `in_data`=0x12345678, `in_amt`=4, `in_tag`=3 → `out_valid` 6 cycles later with `out_data`=0x81234567, `out_amt`=4, `out_tag`=3.
- Boundary amounts: amt 0 on 0xDEADBEEF → 0xDEADBEEF. amt 1 on 0x00000001 → 0x80000000. amt 31 on 0x80000000 → 0x00000001.
- Back-to-back: 32 requests (data=i, amt=i, tag=i mod 16), `out_ready`=1 → one result per cycle, in order, each equal to data rotated right by amt. `in_ready` never drops.
- Backpressure: `out_ready`=0, `in_valid` held high → exactly 8 accepted, `in_ready`=0, `count`=8, `inflight`=0. Then `out_ready`=1 → 8 in-order results, `in_ready` returns.
- Simultaneous: with `count`=8, pop and accept in the same cycle; with `count`=1, a write and a pop land on the same edge → no loss or duplication, `count` stays consistent.
